// File: rtl/mem_io_responder.sv
// Byte-wide memory-bus responder: 2^RAM_ADDR_WIDTH-byte RAM plus I/O window (UART FIFOs, cycle counter, stop register).
// Latency: writes land at the clock edge; read data on bus_rdata one cycle after the address.
// Backpressure: tx via tx_valid/tx_ready (io_buffer_full warns the CPU early), rx via rx_valid/rx_ready.

// Circular FIFO shared by the tx and rx paths. Latency: head visible the cycle after a push into an empty FIFO.
// Backpressure: a push to a full FIFO is accepted only alongside a pop; otherwise it is dropped and drop_o pulses.
// Pops of an empty FIFO are ignored, so callers may request a pop unconditionally.
module mem_io_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               push_i,
  input  logic [W-1:0]       push_dat_i,
  input  logic               pop_i,
  output logic [W-1:0]       head_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic               empty_o,
  output logic               full_o,
  output logic               drop_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == FULL_CNT);
  assign count_o = cnt_q;
  assign head_o  = mem[rd_q];

  // Pop first, then a push may reuse the slot the pop frees.
  always_comb begin
    do_pop  = pop_i && !empty_o;
    do_push = push_i && (!full_o || do_pop);
    drop_o  = push_i && !do_push;
    rd_d    = do_pop  ? rd_q + AW'(1) : rd_q;
    wr_d    = do_push ? wr_q + AW'(1) : wr_q;
    cnt_d   = cnt_q;
    if (do_push && !do_pop)
      cnt_d = cnt_q + (AW+1)'(1);
    else if (!do_push && do_pop)
      cnt_d = cnt_q - (AW+1)'(1);
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage carries no reset; only slots between the pointers are ever read as valid.
  always_ff @(posedge clk_in) begin
    if (do_push)
      mem[wr_q] <= push_dat_i;
  end
endmodule

module mem_io_responder #(
  parameter int RAM_ADDR_WIDTH = 17,
  parameter int TX_DEPTH       = 16,
  parameter int RX_DEPTH       = 16
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] bus_a,
  input  logic        bus_wr,
  input  logic [7:0]  bus_wdata,
  output logic [7:0]  bus_rdata,
  output logic        io_buffer_full,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        program_done,
  output logic        tx_overflow
);
  localparam int TX_AW     = $clog2(TX_DEPTH);
  localparam int RX_AW     = $clog2(RX_DEPTH);
  localparam int RAM_BYTES = 1 << RAM_ADDR_WIDTH;
  localparam int TX_HIGH   = TX_DEPTH - 2;

  // Decode.
  logic        io_sel, is_rd;
  logic        off_data, off_cnt, off_s1, off_s2, off_s3;
  logic [15:0] io_off;
  logic        unused_hi_addr;

  // tx path.
  logic             tx_push, tx_empty, tx_full, tx_drop;
  logic [7:0]       tx_push_dat;
  logic [TX_AW:0]   tx_count;

  // rx path.
  logic             rx_push, rx_pop, rx_empty, rx_full;
  logic [7:0]       rx_head;
  logic [RX_AW:0]   unused_rx_count;
  logic             unused_rx_drop;

  // State.
  logic [31:0] cycle_q, cycle_d;
  logic [23:0] snap_q, snap_d;
  logic [7:0]  io_rdata_q, io_rdata_d;
  logic        rd_ram_q, rd_ram_d;
  logic        done_q, done_d;
  logic        ovf_q, ovf_d;

  // RAM.
  logic [7:0]                ram_mem [RAM_BYTES];
  logic [7:0]                ram_dout_q;
  logic [RAM_ADDR_WIDTH-1:0] ram_addr;
  logic                      ram_we, ram_re;

  assign unused_hi_addr = ^bus_a[31:18];
  assign ram_addr       = bus_a[RAM_ADDR_WIDTH-1:0];

  // Address decode: the top two decoded bits pick the I/O window, the low half-word picks the register.
  always_comb begin
    io_sel   = (bus_a[17:16] == 2'b11);
    io_off   = bus_a[15:0];
    is_rd    = !bus_wr;
    off_data = (io_off == 16'h0000);
    off_cnt  = (io_off == 16'h0004);
    off_s1   = (io_off == 16'h0005);
    off_s2   = (io_off == 16'h0006);
    off_s3   = (io_off == 16'h0007);
    ram_we   = bus_wr && !io_sel;
    ram_re   = is_rd && !io_sel;
  end

  // Bus-side FIFO requests: data writes push non-zero bytes, the stop write pushes the 0x00 end marker.
  always_comb begin
    tx_push     = bus_wr && io_sel && ((off_data && (bus_wdata != 8'h00)) || off_cnt);
    tx_push_dat = off_cnt ? 8'h00 : bus_wdata;
    rx_pop      = is_rd && io_sel && off_data;
    rx_push     = rx_valid && !rx_full;
  end

  mem_io_fifo #(.W(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .push_i     (tx_push),
    .push_dat_i (tx_push_dat),
    .pop_i      (tx_ready),
    .head_o     (tx_data),
    .count_o    (tx_count),
    .empty_o    (tx_empty),
    .full_o     (tx_full),
    .drop_o     (tx_drop)
  );

  mem_io_fifo #(.W(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .push_i     (rx_push),
    .push_dat_i (rx_data),
    .pop_i      (rx_pop),
    .head_o     (rx_head),
    .count_o    (unused_rx_count),
    .empty_o    (rx_empty),
    .full_o     (rx_full),
    .drop_o     (unused_rx_drop)
  );

  // The two-entry slack covers the CPU seeing this flag one cycle late.
  assign io_buffer_full = (32'(tx_count) >= TX_HIGH);
  assign tx_valid       = !tx_empty;
  assign rx_ready       = !rx_full;
  assign program_done   = done_q;
  assign tx_overflow    = ovf_q;

  // Read-return source: I/O reads load io_rdata_q, RAM reads load ram_dout_q; writes touch neither.
  assign bus_rdata = rd_ram_q ? ram_dout_q : io_rdata_q;

  // Next-state for counter, snapshot, I/O read data and sticky flags.
  always_comb begin
    cycle_d    = cycle_q + 32'd1;
    snap_d     = snap_q;
    io_rdata_d = io_rdata_q;
    rd_ram_d   = rd_ram_q;
    done_d     = done_q;
    ovf_d      = ovf_q || (tx_drop && !tx_full) || (tx_drop && tx_full);
    if (is_rd) begin
      rd_ram_d = !io_sel;
      if (io_sel) begin
        io_rdata_d = 8'h00;
        if (off_data) begin
          io_rdata_d = rx_empty ? 8'h00 : rx_head;
        end else if (off_cnt) begin
          io_rdata_d = cycle_q[7:0];
          snap_d     = cycle_q[31:8];
        end else if (off_s1) begin
          io_rdata_d = snap_q[7:0];
        end else if (off_s2) begin
          io_rdata_d = snap_q[15:8];
        end else if (off_s3) begin
          io_rdata_d = snap_q[23:16];
        end
      end
    end else if (io_sel && off_cnt) begin
      done_d = 1'b1;
    end
  end

  // Control registers; reset also discards any read in flight.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      cycle_q    <= '0;
      snap_q     <= '0;
      io_rdata_q <= '0;
      rd_ram_q   <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      cycle_q    <= cycle_d;
      snap_q     <= snap_d;
      io_rdata_q <= io_rdata_d;
      rd_ram_q   <= rd_ram_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
    end
  end

  // Single-port synchronous RAM; contents and read register are deliberately not reset.
  always_ff @(posedge clk_in) begin
    if (ram_we)
      ram_mem[ram_addr] <= bus_wdata;
    else if (ram_re)
      ram_dout_q <= ram_mem[ram_addr];
  end
endmodule

// File: tb/tb_mem_io_responder.sv
// Self-checking bench for mem_io_responder: directed scenarios then randomized traffic.
// Expected values come from a queue/array model of the memory map.
// Every cycle, all outputs are compared against the model.
module tb_mem_io_responder;
  localparam int TXD = 16;
  localparam int RXD = 16;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic [31:0] bus_a = '0;
  logic        bus_wr = 1'b0;
  logic [7:0]  bus_wdata = '0;
  logic [7:0]  bus_rdata;
  logic        io_buffer_full;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_ready;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready = 1'b0;
  logic        program_done;
  logic        tx_overflow;

  mem_io_responder #(.RAM_ADDR_WIDTH(17), .TX_DEPTH(TXD), .RX_DEPTH(RXD)) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .bus_a          (bus_a),
    .bus_wr         (bus_wr),
    .bus_wdata      (bus_wdata),
    .bus_rdata      (bus_rdata),
    .io_buffer_full (io_buffer_full),
    .rx_valid       (rx_valid),
    .rx_data        (rx_data),
    .rx_ready       (rx_ready),
    .tx_valid       (tx_valid),
    .tx_data        (tx_data),
    .tx_ready       (tx_ready),
    .program_done   (program_done),
    .tx_overflow    (tx_overflow)
  );

  always #5 clk_in = ~clk_in;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model.
  logic [7:0]  txq[$];
  logic [7:0]  rxq[$];
  logic [7:0]  mem_m [int];
  logic [7:0]  exp_rd   = 8'h00;
  bit          exp_done = 1'b0;
  bit          exp_ovf  = 1'b0;
  int unsigned cyc      = 0;
  logic [31:0] snap_m   = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_all(input string tag);
    check({tag, ":rdata"}, bus_rdata, exp_rd);
    check({tag, ":tx_valid"}, tx_valid, txq.size() > 0);
    if (txq.size() > 0) check({tag, ":tx_data"}, tx_data, txq[0]);
    check({tag, ":rx_ready"}, rx_ready, rxq.size() < RXD);
    check({tag, ":iobf"}, io_buffer_full, txq.size() >= TXD - 2);
    check({tag, ":done"}, program_done, exp_done);
    check({tag, ":ovf"}, tx_overflow, exp_ovf);
  endtask

  // One bus cycle: drive, update the model with the pre-edge state, clock, compare.
  task automatic tick(input logic [31:0] a, input bit wr, input logic [7:0] wd,
                      input bit rxv, input logic [7:0] rxd, input bit txr, input string tag);
    bit io, txpop, rxpush, push_req;
    logic [15:0] off;
    int key;
    bus_a = a; bus_wr = wr; bus_wdata = wd; rx_valid = rxv; rx_data = rxd; tx_ready = txr;
    io     = (a[31:0] >> 16 & 32'h3) == 32'h3;
    off    = a[15:0];
    key    = int'(a[16:0]);
    txpop  = txq.size() > 0 && txr;
    rxpush = rxv && rxq.size() < RXD;
    if (!wr) begin
      if (!io) exp_rd = mem_m[key];
      else if (off == 16'h0) exp_rd = (rxq.size() > 0) ? rxq.pop_front() : 8'h00;
      else if (off == 16'h4) begin exp_rd = cyc[7:0]; snap_m = cyc; end
      else if (off == 16'h5) exp_rd = snap_m[15:8];
      else if (off == 16'h6) exp_rd = snap_m[23:16];
      else if (off == 16'h7) exp_rd = snap_m[31:24];
      else exp_rd = 8'h00;
    end else if (!io) begin
      mem_m[key] = wd;
    end
    if (rxpush) rxq.push_back(rxd);
    if (txpop) void'(txq.pop_front());
    push_req = wr && io && ((off == 16'h0 && wd != 8'h00) || off == 16'h4);
    if (push_req) begin
      if (txq.size() < TXD) txq.push_back(off == 16'h4 ? 8'h00 : wd);
      else exp_ovf = 1'b1;
    end
    if (wr && io && off == 16'h4) exp_done = 1'b1;
    @(posedge clk_in);
    cyc++;
    #1;
    check_all(tag);
  endtask

  task automatic idle(input int n, input bit txr);
    for (int i = 0; i < n; i++) tick(32'h0, 1'b0, 8'h00, 1'b0, 8'h00, txr, "idle");
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] r;
    logic [15:0] offs [8];
    r = $urandom();
    offs = '{16'h0, 16'h0, 16'h4, 16'h5, 16'h6, 16'h7, 16'h1, 16'h8};
    if ($urandom_range(0, 1) == 0)
      return {r[31:18], r[17], 1'b0, 10'b0, 6'($urandom_range(0, 63))};
    return {r[31:18], 2'b11, offs[$urandom_range(0, 7)]};
  endfunction

  initial begin
    logic [7:0] wd;
    // Reset state before any clock edge.
    #1;
    check_all("reset0");
    @(posedge clk_in);
    #2;
    check_all("reset_hold");
    rst_in = 1'b1;

    // Preload the RAM window the random traffic uses.
    for (int i = 0; i < 64; i++)
      tick(32'(i), 1'b1, 8'($urandom()), 1'b0, 8'h00, 1'b0, "preload");

    // RAM write/read with an intermediate write holding bus_rdata.
    tick(32'h0000_0003, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, "ram_rd3");
    tick(32'h0000_0010, 1'b1, 8'hA5, 1'b0, 8'h00, 1'b0, "ram_wr");
    tick(32'h0000_0011, 1'b1, 8'h5A, 1'b0, 8'h00, 1'b0, "ram_wr_hold");
    tick(32'hFFFC_0010, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, "ram_rd");
    check("ram_a5", bus_rdata, 8'hA5);

    // Counter snapshot, later bytes read after the counter has moved on.
    idle(300, 1'b0);
    tick(32'h0003_0004, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, "cnt_lo");
    idle(7, 1'b0);
    tick(32'h0003_0005, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, "cnt_b1");
    tick(32'h0003_0006, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, "cnt_b2");
    tick(32'h0003_0007, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, "cnt_b3");

    // tx fill to overflow, then drain.
    for (int i = 0; i < 17; i++) begin
      tick(32'h0003_0000, 1'b1, 8'h41, 1'b0, 8'h00, 1'b0, "tx_fill");
      if (i == 12) check("iobf_13", io_buffer_full, 1'b0);
      if (i == 13) check("iobf_14", io_buffer_full, 1'b1);
      if (i == 15) check("ovf_16", tx_overflow, 1'b0);
    end
    check("ovf_17", tx_overflow, 1'b1);
    idle(17, 1'b1);
    check("tx_drained", tx_valid, 1'b0);

    // Zero write ignored; stop write sets done and pushes the marker.
    tick(32'h0003_0000, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0, "tx_zero");
    check("tx_zero_vld", tx_valid, 1'b0);
    tick(32'h0003_0004, 1'b1, 8'h77, 1'b0, 8'h00, 1'b0, "stop");
    check("stop_done", program_done, 1'b1);
    check("stop_mark", {tx_valid, tx_data}, 9'h100);
    idle(2, 1'b1);

    // rx: two bytes, three reads; then pop racing the first push into an empty FIFO.
    tick(32'h0, 1'b0, 8'h00, 1'b1, 8'h31, 1'b0, "rx_push1");
    tick(32'h0, 1'b0, 8'h00, 1'b1, 8'h32, 1'b0, "rx_push2");
    for (int i = 0; i < 3; i++)
      tick(32'h0003_0000, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, "rx_pop");
    tick(32'h0003_0000, 1'b0, 8'h00, 1'b1, 8'h55, 1'b0, "rx_race");
    check("rx_race_zero", bus_rdata, 8'h00);
    tick(32'h0003_0000, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, "rx_after");
    check("rx_after_55", bus_rdata, 8'h55);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      wd = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom());
      tick(rand_addr(), $urandom_range(0, 2) == 0, wd,
           $urandom_range(0, 2) == 0, 8'($urandom()), $urandom_range(0, 3) != 0, "rand");
    end

    // Asynchronous reset with bytes queued on both sides.
    idle(20, 1'b1);
    for (int i = 0; i < 5; i++)
      tick(32'h0003_0000, 1'b1, 8'(i + 1), 1'b1, 8'(i + 8'h60), 1'b0, "preq");
    check("preq_vld", tx_valid, 1'b1);
    bus_a = 32'h0; bus_wr = 1'b0; rx_valid = 1'b0; tx_ready = 1'b0;
    rst_in = 1'b0;
    txq.delete(); rxq.delete();
    exp_rd = 8'h00; exp_done = 1'b0; exp_ovf = 1'b0; snap_m = '0;
    #1;
    check_all("async_rst");
    repeat (2) @(posedge clk_in);
    #1;
    rst_in = 1'b1;
    cyc = 0;
    tick(32'h0003_0004, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, "cnt_restart");
    check("cnt_zero", bus_rdata, 8'h00);
    tick(32'h0003_0004, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, "cnt_one");
    for (int i = 0; i < 200; i++)
      tick(rand_addr(), $urandom_range(0, 2) == 0, 8'($urandom()),
           $urandom_range(0, 1) == 0, 8'($urandom()), $urandom_range(0, 1) == 0, "rand2");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/mem_io_responder.md
Name: mem_io_responder

Overview:
- Memory-side responder for the CPU's byte-wide memory bus (address, write strobe, 8-bit data each way); it is the far end of the bus the CPU's memory controller drives.
- Implements the byte-addressed RAM and the memory-mapped I/O window: UART rx/tx byte streams, the elapsed-clock counter, and the program-stop register.
- Sits between the CPU top and the UART/host glue in the board-level wrapper.

Parameters:
- RAM_ADDR_WIDTH, 17, RAM is 2^RAM_ADDR_WIDTH bytes (128 KB).
- TX_DEPTH, 16, tx FIFO entries; must be a power of 2 and at least 4.
- RX_DEPTH, 16, rx FIFO entries; must be a power of 2.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  reset, asynchronous, active-low
- bus_a  input  32  byte address from CPU; only [17:0] decoded
- bus_wr  input  1  1 = write this cycle, 0 = read
- bus_wdata  input  8  write byte from CPU
- bus_rdata  output  8  read byte to CPU, registered
- io_buffer_full  output  1  tx FIFO nearly full; CPU must not write 0x30000
- rx_valid  input  1  incoming UART byte available
- rx_data  input  8  incoming UART byte
- rx_ready  output  1  rx FIFO can accept a byte
- tx_valid  output  1  tx FIFO non-empty
- tx_data  output  8  head of tx FIFO
- tx_ready  input  1  UART accepts head byte
- program_done  output  1  sticky; set by stop write
- tx_overflow  output  1  sticky; tx push dropped because the FIFO was full

Behaviour:
- Address decode:
  - bus_a[17:16] == 2'b11 selects I/O.
  - Otherwise the access goes to RAM at bus_a[RAM_ADDR_WIDTH-1:0].
  - Address bits [31:18] are ignored.
- RAM:
  - Single-port and synchronous.
  - Write takes effect at the clock edge; no wait.
  - Read data appears on bus_rdata exactly one cycle after the address is presented.
  - RAM contents are not reset.
- bus_rdata:
  - Resets to 0x00.
  - Updated on every read cycle.
  - Holds its value on write cycles.
- I/O reads (data returned next cycle):
  - 0x30000: pop the rx FIFO and return its head. If the FIFO is empty, return 0x00 and do not pop.
  - 0x30004: return cycle_count[7:0] and capture cycle_count[31:8] into a snapshot register.
  - 0x30005, 0x30006, 0x30007: return snapshot bytes [15:8], [23:16], [31:24] respectively.
  - Any other I/O address: return 0x00.
- I/O writes:
  - 0x30000 with data != 0x00: push into tx FIFO. Data 0x00 is ignored.
  - 0x30004: set program_done and push 0x00 into tx FIFO (end-of-output marker). Written data is ignored.
  - Other I/O addresses: no effect.
- cycle_count:
  - 32-bit counter, 0 at reset, +1 every cycle.
  - Wraps 0xFFFFFFFF -> 0.
- tx FIFO:
  - Circular buffer with head/tail pointers and a count of width log2(TX_DEPTH)+1.
  - Pop when tx_valid && tx_ready.
  - Push and pop in the same cycle: both occur and count is unchanged. A push to a full FIFO with a simultaneous pop is accepted.
  - Push when full with no pop: byte dropped, tx_overflow set.
  - io_buffer_full = (count >= TX_DEPTH-2). The two entries of slack cover the CPU's one-cycle-late view of the flag.
- rx FIFO:
  - rx_ready = !full.
  - Push when rx_valid && rx_ready.
  - A bus pop and an rx push in the same cycle are both honoured. If the FIFO was empty, the pop returns 0x00 and the pushed byte stays queued.
- program_done:
  - Once set, stays set until reset.
  - Bus accesses are still serviced after it is set.
- Reset (asynchronous assert, synchronous deassert by the wrapper):
  - FIFOs emptied, counter and snapshot cleared.
  - bus_rdata = 0x00, tx_valid = 0, rx_ready = 1, io_buffer_full = 0, program_done = 0, tx_overflow = 0.
  - A read in flight at reset is discarded.

Test Plan:
- Write RAM 0x00010 = 0xA5, then read 0x00010 -> bus_rdata = 0xA5 one cycle after the read address; the intermediate write cycle leaves bus_rdata unchanged.
- Hold tx_ready = 0 and write 0x41 fourteen times to 0x30000 with TX_DEPTH = 16 -> io_buffer_full rises after the 14th push. Two more pushes are accepted and a 17th sets tx_overflow. Then raise tx_ready -> 16 bytes of 0x41 drain, one per cycle.
- Write 0x00 to 0x30000 -> tx_valid stays 0. Write to 0x30004 -> program_done = 1 and tx_data = 0x00 with tx_valid = 1.
- Read 0x30004 at cycle_count = 0x12345678, then 0x30005/6/7 several cycles later -> returns 0x78, 0x56, 0x34, 0x12; later reads are unaffected by counter advance.
- Push rx bytes 0x31, 0x32, then read 0x30000 three times -> 0x31, 0x32, 0x00. Also read 0x30000 on the same cycle as the first push into an empty FIFO -> 0x00 returned, and the next read returns the byte.
- Assert rst_in low mid-transfer with 5 bytes queued -> outputs take their reset values immediately without a clock edge; after release, counter restarts from 0.
